// File: rtl/face_detect_pkg.sv
// Shared types and helpers for the multi-scale face detector.
// Sequencer state encoding and result-word packing live here.
package face_detect_pkg;

  typedef enum logic [1:0] {
    S_WAIT,
    S_LOG,
    S_READY
  } seq_state_t;

  function automatic int scale_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int result_width(input int n, input int cw);
    return scale_width(n) + 2 * cw;
  endfunction

  function automatic logic [63:0] pack_result(
    input logic [31:0] s,
    input logic [31:0] y,
    input logic [31:0] x,
    input int          cw
  );
    return (64'(s) << (2 * cw)) | (64'(y) << cw) | 64'(x);
  endfunction

  function automatic logic [31:0] unpack_x(
    input logic [63:0] w,
    input int          cw
  );
    return 32'(w & ((64'd1 << cw) - 64'd1));
  endfunction

  function automatic logic [31:0] unpack_y(
    input logic [63:0] w,
    input int          cw
  );
    return 32'((w >> cw) & ((64'd1 << cw) - 64'd1));
  endfunction

  function automatic logic [31:0] unpack_scale(
    input logic [63:0] w,
    input int          cw
  );
    return 32'(w >> (2 * cw));
  endfunction

endpackage

// File: rtl/scale_detect_sequencer_if.sv
// Host/channel bundle of the scale detect sequencer.
// master drives pixels, channel flags and result pops.
interface scale_detect_sequencer_if
  import face_detect_pkg::*;
#(
  parameter int NUM_CHANNELS = 5,
  parameter int PIXEL_WIDTH  = 16,
  parameter int COORD_WIDTH  = 12
);

  localparam int RESULT_WIDTH =
    result_width(NUM_CHANNELS, COORD_WIDTH);

  logic                    i_pixel_valid;
  logic [PIXEL_WIDTH-1:0]  i_pixel;
  logic                    o_pixel_ready;
  logic                    o_pixel_valid;
  logic [PIXEL_WIDTH-1:0]  o_pixel;
  logic [COORD_WIDTH-1:0]  o_ori_x;
  logic [COORD_WIDTH-1:0]  o_ori_y;
  logic                    o_db_reset;
  logic                    o_frame_end;
  logic [NUM_CHANNELS-1:0] i_chan_req;
  logic [NUM_CHANNELS-1:0] i_chan_cand;
  logic                    o_result_valid;
  logic [RESULT_WIDTH-1:0] o_result_data;
  logic                    i_result_ready;
  logic                    o_overflow;

  modport master (
    output i_pixel_valid, i_pixel,
    output i_chan_req, i_chan_cand,
    output i_result_ready,
    input  o_pixel_ready, o_pixel_valid, o_pixel,
    input  o_ori_x, o_ori_y, o_db_reset, o_frame_end,
    input  o_result_valid, o_result_data, o_overflow
  );

  modport slave (
    input  i_pixel_valid, i_pixel,
    input  i_chan_req, i_chan_cand,
    input  i_result_ready,
    output o_pixel_ready, o_pixel_valid, o_pixel,
    output o_ori_x, o_ori_y, o_db_reset, o_frame_end,
    output o_result_valid, o_result_data, o_overflow
  );

endinterface

// File: rtl/result_fifo.sv
// First-word fall-through result FIFO.
// A push into a full FIFO is taken when a pop happens in the same cycle.
module result_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/scale_detect_sequencer.sv
// Frame-level pixel broadcast and candidate logging sequencer.
// Pixels go out only when every scale channel has asked for one.
module scale_detect_sequencer
  import face_detect_pkg::*;
#(
  parameter int NUM_CHANNELS = 5,
  parameter int FRAME_WIDTH  = 800,
  parameter int FRAME_HEIGHT = 600,
  parameter int PIXEL_WIDTH  = 16,
  parameter int COORD_WIDTH  = 12,
  parameter int FIFO_DEPTH   = 16,
  parameter int DROP_ON_FULL = 0
) (
  input logic clk,
  input logic reset,
  scale_detect_sequencer_if.slave bus
);

  localparam int SW = scale_width(NUM_CHANNELS);
  localparam int RW = result_width(NUM_CHANNELS, COORD_WIDTH);
  localparam logic [COORD_WIDTH-1:0] X_LAST =
    COORD_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] Y_LAST =
    COORD_WIDTH'(FRAME_HEIGHT - 1);
  localparam logic [COORD_WIDTH-1:0] C_ONE = COORD_WIDTH'(1);
  localparam logic [NUM_CHANNELS-1:0] M_ONE = NUM_CHANNELS'(1);

  seq_state_t state;
  seq_state_t state_nx;

  logic [NUM_CHANNELS-1:0] mask;
  logic [NUM_CHANNELS-1:0] mask_nx;
  logic [NUM_CHANNELS-1:0] low_bit;
  logic [SW-1:0]           idx;

  logic                   ready_q;
  logic                   pix_valid_q;
  logic                   frame_end_q;
  logic                   overflow_q;
  logic [PIXEL_WIDTH-1:0] pixel_q;
  logic [COORD_WIDTH-1:0] ori_x;
  logic [COORD_WIDTH-1:0] ori_y;
  logic [COORD_WIDTH-1:0] next_x;
  logic [COORD_WIDTH-1:0] next_y;

  logic          accept;
  logic          at_last;
  logic          pop;
  logic          push;
  logic          drop;
  logic          full;
  logic          empty;
  logic [RW-1:0] word;
  logic [RW-1:0] head;

  assign accept  = (state == S_READY) && ready_q
                   && bus.i_pixel_valid;
  assign at_last = (next_x == X_LAST) && (next_y == Y_LAST);
  assign pop     = bus.i_result_ready && !empty;
  assign low_bit = mask & (~mask + M_ONE);
  assign word    = RW'(pack_result(32'(idx), 32'(ori_y),
                                   32'(ori_x), COORD_WIDTH));

  // lowest pending candidate channel
  always_comb begin
    idx = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (mask[i]) idx = SW'(i);
    end
  end

  // next state, candidate mask and FIFO push/drop
  always_comb begin
    state_nx = state;
    mask_nx  = mask;
    push     = 1'b0;
    drop     = 1'b0;
    unique case (state)
      S_WAIT: begin
        if (!pix_valid_q && (&bus.i_chan_req)) begin
          mask_nx  = bus.i_chan_cand;
          state_nx = (bus.i_chan_cand != '0) ? S_LOG : S_READY;
        end
      end
      S_LOG: begin
        if (!full || pop) begin
          push = 1'b1;
        end else if (DROP_ON_FULL != 0) begin
          drop = 1'b1;
        end
        if (push || drop) mask_nx = mask & ~low_bit;
        if (mask_nx == '0) state_nx = S_READY;
      end
      S_READY: begin
        if (accept) state_nx = S_WAIT;
      end
      default: state_nx = S_WAIT;
    endcase
  end

  // FSM state, mask and handshake flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_WAIT;
      mask        <= '0;
      ready_q     <= 1'b0;
      pix_valid_q <= 1'b0;
      frame_end_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state       <= state_nx;
      mask        <= mask_nx;
      ready_q     <= (state == S_READY) && !accept;
      pix_valid_q <= accept;
      frame_end_q <= accept && at_last;
      if (drop) overflow_q <= 1'b1;
    end
  end

  // broadcast pixel and raster coordinate counter
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_q <= '0;
      ori_x   <= '0;
      ori_y   <= '0;
      next_x  <= '0;
      next_y  <= '0;
    end else if (accept) begin
      pixel_q <= bus.i_pixel;
      ori_x   <= next_x;
      ori_y   <= next_y;
      if (next_x == X_LAST) begin
        next_x <= '0;
        next_y <= (next_y == Y_LAST) ? '0 : next_y + C_ONE;
      end else begin
        next_x <= next_x + C_ONE;
      end
    end
  end

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RW)
  ) fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (word),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign bus.o_pixel_ready  = ready_q;
  assign bus.o_pixel_valid  = pix_valid_q;
  assign bus.o_db_reset     = pix_valid_q;
  assign bus.o_pixel        = pixel_q;
  assign bus.o_ori_x        = ori_x;
  assign bus.o_ori_y        = ori_y;
  assign bus.o_frame_end    = frame_end_q;
  assign bus.o_result_valid = !empty;
  assign bus.o_result_data  = head;
  assign bus.o_overflow     = overflow_q;

endmodule
